// File: rtl/util_pkg.sv
`default_nettype none
// util_pkg: small helpers shared by the schedulers and arbiters.
package util_pkg;

  // Increment with wrap at an arbitrary (not necessarily power-of-2) bound.
  function automatic int unsigned rr_next(input int unsigned cur, input int unsigned bound);
    return (cur + 1 >= bound) ? 0 : cur + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_arbiter_rr_pick.sv
`default_nettype none
// rr_pick: combinational round-robin scan; first set req bit starting at prio, wrapping at N.
module rr_pick #(
  parameter int N = 2,
  localparam int ID_WIDTH = $clog2(N)
) (
  input  logic [N-1:0]        req,
  input  logic [ID_WIDTH-1:0] prio,
  output logic [ID_WIDTH-1:0] sel,
  output logic                any
);

  localparam int unsigned NU = N;

  function automatic logic [ID_WIDTH-1:0] add_mod(input logic [ID_WIDTH-1:0] base,
                                                  input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NU) s = s - NU;
    return ID_WIDTH'(s);
  endfunction

  // Scan from the far end back toward prio so the last hit is the first in priority order.
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[add_mod(prio, k)]) begin
        sel = add_mod(prio, k);
        any = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_arbiter.sv
`default_nettype none
// stream_arbiter: round-robin merge of N valid/ready streams into one registered output.
// Define STREAM_ARBITER_PKT_LOCK_EN to hold a grant until the packet's last beat.
module stream_arbiter
  import util_pkg::*;
#(
  parameter int N = 2,
  parameter int DATA_WIDTH = 1,
  parameter type TYPE = logic [DATA_WIDTH-1:0],
  localparam int ID_WIDTH = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        in_valid,
  output logic [N-1:0]        in_ready,
  input  TYPE                 in_data [N],
  input  logic [N-1:0]        in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output TYPE                 out_data,
  output logic                out_last,
  output logic [ID_WIDTH-1:0] out_id
);

  logic                load;
  logic                any;
  logic                accept;
  logic                advance;
  logic                rr_any;
  logic [ID_WIDTH-1:0] sel;
  logic [ID_WIDTH-1:0] rr_sel;
  logic [ID_WIDTH-1:0] prio;

  rr_pick #(.N(N)) u_pick (
    .req  (in_valid),
    .prio (prio),
    .sel  (rr_sel),
    .any  (rr_any)
  );

`ifdef STREAM_ARBITER_PKT_LOCK_EN
  logic                locked;
  logic [ID_WIDTH-1:0] lock_id;

  // While locked, only the owning source may be granted, even if it idles.
  always_comb begin
    sel = locked ? lock_id : rr_sel;
    any = locked ? in_valid[lock_id] : rr_any;
  end

  assign advance = accept && in_last[sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      locked  <= 1'b0;
      lock_id <= '0;
    end else if (accept) begin
      locked <= !in_last[sel];
      if (!in_last[sel]) lock_id <= sel;
    end
  end
`else
  assign sel     = rr_sel;
  assign any     = rr_any;
  assign advance = accept;
`endif

  assign load   = !out_valid || out_ready;
  assign accept = load && any;

  for (genvar i = 0; i < N; i++) begin : g_ready
    assign in_ready[i] = accept && (sel == ID_WIDTH'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_id    <= '0;
    end else if (load) begin
      out_valid <= any;
      if (any) begin
        out_data <= in_data[sel];
        out_last <= in_last[sel];
        out_id   <= sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= '0;
    end else if (advance) begin
      prio <= ID_WIDTH'(rr_next(32'(sel), N));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// tb_stream_arbiter: scoreboard bench with a behavioural round-robin model.
module tb_stream_arbiter;

  localparam int N  = 3;
  localparam int DW = 8;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [N-1:0]  in_last;
  logic [DW-1:0] in_data [N];
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [1:0]    out_id;

  stream_arbiter #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  beat_t q[$];
  int    seen[$];
  int    checks = 0;
  int    errors = 0;
  int    m_prio = 0;
  bit    m_locked = 1'b0;
  int    m_lock_id = 0;

  // Monitor: the front of the queue is what must currently sit on the output.
  always @(negedge clk) begin
    checks++;
    if (out_valid !== (q.size() != 0)) begin
      errors++;
      $display("FAIL out_valid: got %b expected %b", out_valid, q.size() != 0);
    end
    if (out_valid === 1'b1 && q.size() != 0) begin
      checks++;
      if ({out_id, out_data, out_last} !== q[0]) begin
        errors++;
        $display("FAIL out_beat: got id=%0d data=%h last=%b expected id=%0d data=%h last=%b",
                 out_id, out_data, out_last, q[0].id, q[0].data, q[0].last);
      end
      if (out_ready) begin
        seen.push_back(int'(out_id));
        void'(q.pop_front());
      end
    end
  end

  // Reference model: grant the valid requester at the smallest cyclic distance from prio.
  always @(negedge clk) begin
    bit           load;
    int           g;
    int           bestd;
    int           d;
    logic [N-1:0] exp_ready;
    #1;
    load  = (q.size() == 0) || out_ready;
    g     = -1;
    bestd = N;
    if (m_locked) begin
      if (in_valid[m_lock_id]) g = m_lock_id;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (in_valid[i]) begin
          d = (i - m_prio + N) % N;
          if (d < bestd) begin
            bestd = d;
            g     = i;
          end
        end
      end
    end
    exp_ready = (load && g >= 0) ? (N'(1) << g) : '0;
    checks++;
    if (in_ready !== exp_ready) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b", in_ready, exp_ready);
    end
    if (rst) begin
      q.delete();
      m_prio    = 0;
      m_locked  = 1'b0;
      m_lock_id = 0;
    end else if (load && g >= 0) begin
      q.push_back({2'(g), in_data[g], in_last[g]});
`ifdef STREAM_ARBITER_PKT_LOCK_EN
      if (in_last[g]) begin
        m_locked = 1'b0;
        m_prio   = (g + 1) % N;
      end else begin
        m_locked  = 1'b1;
        m_lock_id = g;
      end
`else
      m_prio = (g + 1) % N;
`endif
    end
  end

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic r);
    in_valid  = v;
    in_last   = l;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_seq(input string name, input int exp[$]);
    checks++;
    if (seen.size() != exp.size()) begin
      errors++;
      $display("FAIL %s length: got %0d expected %0d", name, seen.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        checks++;
        if (seen[i] != exp[i]) begin
          errors++;
          $display("FAIL %s[%0d]: got id %0d expected %0d", name, i, seen[i], exp[i]);
        end
      end
    end
    seen.delete();
  endtask

  initial begin
    int exp[$];
    rst       = 1'b1;
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i] = 8'hA0 + 8'(i);
    do_reset();

    checks++;
    if (out_id !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got id=%0d valid=%b expected id=0 valid=0", out_id, out_valid);
    end

    // Fairness: everybody valid, drained every cycle.
    seen.delete();
    repeat (6) drive('1, '0, 1'b1);
    repeat (2) drive('0, '0, 1'b1);
    exp = '{0, 1, 2, 0, 1, 2};
    check_seq("fairness", exp);

    // Backpressure: one accept, three stalled cycles, then release.
    drive('1, '0, 1'b0);
    repeat (3) drive('1, '0, 1'b0);
    repeat (2) drive('1, '0, 1'b1);
    repeat (2) drive('0, '0, 1'b1);
    exp = '{0, 1, 2};
    check_seq("backpressure", exp);

    // Wrap: move prio to N-1, then requesters 0 and 2 compete.
    drive(3'b010, '0, 1'b1);
    repeat (2) drive(3'b101, '0, 1'b1);
    repeat (2) drive('0, '0, 1'b1);
    exp = '{1, 2, 0};
    check_seq("wrap", exp);

    // Packet from requester 0 (last 0,0,1) with a valid gap; requester 1 always valid.
    do_reset();
    seen.delete();
    drive(3'b011, 3'b000, 1'b1);
    drive(3'b010, 3'b000, 1'b1);
    drive(3'b011, 3'b000, 1'b1);
    drive(3'b011, 3'b001, 1'b1);
    drive(3'b010, 3'b010, 1'b1);
    repeat (2) drive('0, '0, 1'b1);
`ifdef STREAM_ARBITER_PKT_LOCK_EN
    exp = '{0, 0, 0, 1};
`else
    exp = '{0, 1, 0, 1, 1};
`endif
    check_seq("lock", exp);

    // Reset in the middle of a packet from requester 1 with the output stalled.
    do_reset();
    drive(3'b010, 3'b000, 1'b1);
    in_valid  = '0;
    out_ready = 1'b0;
    do_reset();
    seen.delete();
    drive(3'b011, 3'b011, 1'b1);
    repeat (2) drive('0, '0, 1'b1);
    exp = '{0};
    check_seq("reset_mid_packet", exp);

    // Randomized traffic against the model.
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) in_data[i] = 8'($urandom);
      drive(N'($urandom), N'($urandom), ($urandom_range(0, 3) != 0));
    end
    repeat (3) drive('0, '0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
